l0_buf_v2: RTL and testbench

Parametrised L0 input buffer that feeds the systolic array's row inputs. It holds `row` independent circular FIFOs of `depth` entries, each `bw` bits wide, all written together from one packed word. Reads run in one of two modes: all rows in parallel, or staggered so that row i is read i cycles after row 0. Over the previous L0 it adds configurable depth, runtime mode selection, per-row output valids, synchronous clear, and sticky overflow/underflow flags.

---
 rtl/l0_buf_v2.sv | 158 +++++++++++++++
 tb/tb_l0_buf_v2.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/l0_buf_v2.sv
// l0_buf_v2: L0 input buffer feeding the systolic array rows.
// One circular FIFO per row, all rows written together from a packed word.
// Reads are either parallel (all rows at once) or staggered (row i lags row 0
// by i cycles) through a read-enable chain. Also provides per-row valids,
// synchronous clear and sticky overflow/underflow flags.
module l0_buf_v2 #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [row*bw-1:0]   in,
  input  logic                wr,
  input  logic                rd,
  input  logic                mode,
  input  logic                clr,
  output logic [row*bw-1:0]   out,
  output logic [row-1:0]      o_valid,
  output logic                o_full,
  output logic                o_ready,
  output logic                o_empty,
  output logic                o_busy,
  output logic                o_overflow,
  output logic                o_underflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  // Storage and per-row bookkeeping. All rows are always written together,
  // so a single write pointer serves every row.
  logic [bw-1:0]     r_mem [row][depth];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr [row];
  logic [CW-1:0]     r_cnt [row];
  logic [row-1:0]    r_rdEn;
  logic [row-1:0]    r_valid;
  logic [row*bw-1:0] r_out;
  logic              r_modeQ;
  logic              r_ovf;
  logic              r_unf;

  logic [row-1:0]    w_full;
  logic [row-1:0]    w_empty;
  logic [row-1:0]    w_pop;
  logic [row-1:0]    w_starve;
  logic [row-1:0]    w_rdEnNext;
  logic              w_wrOk;
  logic              w_wrDrop;

  // Per-row status, pop/starve decisions and write acceptance (clear wins).
  always_comb begin
    w_full   = '0;
    w_empty  = '0;
    w_pop    = '0;
    w_starve = '0;
    for (int i = 0; i < row; i++) begin
      w_full[i]   = (r_cnt[i] == CW'(depth));
      w_empty[i]  = (r_cnt[i] == '0);
      w_pop[i]    = r_rdEn[i] & ~w_empty[i] & ~clr;
      w_starve[i] = r_rdEn[i] &  w_empty[i] & ~clr;
    end
    w_wrOk   = wr & ~(|w_full) & ~clr;
    w_wrDrop = wr &  (|w_full) & ~clr;
  end

  // Next read-enable pattern: broadcast in parallel mode, shift in stagger mode.
  always_comb begin
    w_rdEnNext = {row{rd}};
    if (r_modeQ)
      w_rdEnNext = {r_rdEn[row-2:0], rd};
  end

  // Memory array write; left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_wrOk)
      for (int i = 0; i < row; i++)
        r_mem[i][r_wrPtr] <= in[i*bw +: bw];
  end

  // Pointers and occupancy counts; a same-edge write and pop leaves cnt alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      for (int i = 0; i < row; i++) begin
        r_rdPtr[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else if (clr) begin
      r_wrPtr <= '0;
      for (int i = 0; i < row; i++) begin
        r_rdPtr[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      if (w_wrOk)
        r_wrPtr <= r_wrPtr + AW'(1);
      for (int i = 0; i < row; i++) begin
        if (w_pop[i])
          r_rdPtr[i] <= r_rdPtr[i] + AW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_wrOk) - CW'(w_pop[i]);
      end
    end
  end

  // Read-enable chain and mode latch; mode only changes when nothing is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdEn  <= '0;
      r_modeQ <= 1'b0;
    end else if (clr) begin
      r_rdEn  <= '0;
    end else begin
      r_rdEn <= w_rdEnNext;
      if ((r_rdEn == '0) && !rd)
        r_modeQ <= mode;
    end
  end

  // Registered read data and per-row valids; out holds when a row does not pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_valid <= '0;
    end else if (clr) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_pop;
      for (int i = 0; i < row; i++)
        if (w_pop[i])
          r_out[i*bw +: bw] <= r_mem[i][r_rdPtr[i]];
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_wrDrop)
        r_ovf <= 1'b1;
      if (|w_starve)
        r_unf <= 1'b1;
    end
  end

  assign out         = r_out;
  assign o_valid     = r_valid;
  assign o_full      = |w_full;
  assign o_ready     = ~(|w_full);
  assign o_empty     = &w_empty;
  assign o_busy      = |r_rdEn;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

endmodule

// File: tb/tb_l0_buf_v2.sv
// Testbench for l0_buf_v2: directed phases plus randomized traffic, checked
// every cycle against a queue-based behavioural model of the buffer.
module tb_l0_buf_v2;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic [ROW*BW-1:0]   in;
  logic                wr, rd, mode, clr;
  logic [ROW*BW-1:0]   out;
  logic [ROW-1:0]      o_valid;
  logic                o_full, o_ready, o_empty, o_busy, o_overflow, o_underflow;

  int total = 0;
  int bad   = 0;

  // Model state: one queue per row, last delivered word per row, the recent
  // history of read requests (bit 0 = request taken at the latest edge).
  logic [BW-1:0]  mq [ROW][$];
  logic [BW-1:0]  mOut [ROW];
  logic [ROW-1:0] mValid;
  logic [ROW-1:0] mHist;
  logic           mMode, mOvf, mUnf;

  always #5 clk = ~clk;

  l0_buf_v2 #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .mode(mode), .clr(clr),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .o_empty(o_empty), .o_busy(o_busy), .o_overflow(o_overflow),
    .o_underflow(o_underflow)
  );

  // Row i is being read at the coming edge if a request arrived 1 edge ago
  // (parallel) or 1+i edges ago (staggered).
  function automatic logic mEn(input int i);
    return mMode ? mHist[i] : mHist[0];
  endfunction

  function automatic logic mBusy();
    logic b = 1'b0;
    for (int i = 0; i < ROW; i++) b |= mEn(i);
    return b;
  endfunction

  function automatic logic mFull();
    logic f = 1'b0;
    for (int i = 0; i < ROW; i++) if (mq[i].size() == DEPTH) f = 1'b1;
    return f;
  endfunction

  function automatic logic mEmpty();
    logic e = 1'b1;
    for (int i = 0; i < ROW; i++) if (mq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ROW; i++) begin
      mq[i].delete();
      mOut[i] = '0;
    end
    mValid = '0;
    mHist  = '0;
    mMode  = 1'b0;
    mOvf   = 1'b0;
    mUnf   = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic modelStep();
    logic fullNow, busyNow;
    fullNow = mFull();
    busyNow = mBusy();
    if (clr) begin
      for (int i = 0; i < ROW; i++) mq[i].delete();
      mHist  = '0;
      mValid = '0;
    end else begin
      for (int i = 0; i < ROW; i++) begin
        mValid[i] = 1'b0;
        if (mEn(i)) begin
          if (mq[i].size() > 0) begin
            mOut[i]   = mq[i].pop_front();
            mValid[i] = 1'b1;
          end else begin
            mUnf = 1'b1;
          end
        end
      end
      if (wr) begin
        if (!fullNow)
          for (int i = 0; i < ROW; i++) mq[i].push_back(in[i*BW +: BW]);
        else
          mOvf = 1'b1;
      end
      if (!busyNow && !rd && (mode != mMode)) begin
        mMode = mode;
        mHist = '0;
      end
      mHist = {mHist[ROW-2:0], rd};
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic checkAll(input string phase);
    logic [ROW*BW-1:0] expOut;
    for (int i = 0; i < ROW; i++) expOut[i*BW +: BW] = mOut[i];
    checkOutput({phase, ".out"},       64'(out),         64'(expOut));
    checkOutput({phase, ".valid"},     64'(o_valid),     64'(mValid));
    checkOutput({phase, ".full"},      64'(o_full),      64'(mFull()));
    checkOutput({phase, ".ready"},     64'(o_ready),     64'(!mFull()));
    checkOutput({phase, ".empty"},     64'(o_empty),     64'(mEmpty()));
    checkOutput({phase, ".busy"},      64'(o_busy),      64'(mBusy()));
    checkOutput({phase, ".overflow"},  64'(o_overflow),  64'(mOvf));
    checkOutput({phase, ".underflow"}, 64'(o_underflow), 64'(mUnf));
  endtask

  // Drive one cycle of inputs, step the model, then compare just after the edge.
  task automatic applyStimulus(input string phase, input logic w, input logic r,
                               input logic m, input logic c, input logic [ROW*BW-1:0] d);
    wr = w; rd = r; mode = m; clr = c; in = d;
    modelStep();
    @(posedge clk);
    #1;
    checkAll(phase);
  endtask

  task automatic resetDut();
    wr = 0; rd = 0; clr = 0; in = '0; mode = 0;
    reset = 1'b0;
    #2;
    modelReset();
    checkAll("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [ROW*BW-1:0] patWord(input int w);
    logic [ROW*BW-1:0] v;
    for (int i = 0; i < ROW; i++) v[i*BW +: BW] = BW'((w + i) % 16);
    return v;
  endfunction

  initial begin
    reset = 1'b1; wr = 0; rd = 0; mode = 0; clr = 0; in = '0;
    modelReset();
    #1;
    resetDut();

    // Fill to full, then one dropped write.
    for (int w = 0; w < DEPTH; w++) applyStimulus("fill", 1, 0, 0, 0, patWord(w));
    applyStimulus("overflow", 1, 0, 0, 0, patWord(99));

    // Parallel reads: pulse then idle, until empty, then one read on empty.
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus("par_rd", 0, 1, 0, 0, '0);
      applyStimulus("par_idle", 0, 0, 0, 0, '0);
    end
    applyStimulus("underflow_rd", 0, 1, 0, 0, '0);
    applyStimulus("underflow_idle", 0, 0, 0, 0, '0);
    applyStimulus("underflow_idle", 0, 0, 0, 0, '0);

    // Staggered read of 3 words; mode toggled while the chain drains.
    for (int w = 0; w < 8; w++) applyStimulus("refill", 1, 0, 1, 0, patWord(w));
    applyStimulus("mode_set", 0, 0, 1, 0, '0);
    for (int k = 0; k < 3; k++) applyStimulus("stag_rd", 0, 1, 1, 0, '0);
    for (int k = 0; k < 12; k++) applyStimulus("stag_drain", 0, 0, k[0], 0, '0);
    applyStimulus("mode_back", 0, 0, 0, 0, '0);
    applyStimulus("par_after", 0, 1, 0, 0, '0);
    for (int k = 0; k < 3; k++) applyStimulus("par_after_idle", 0, 0, 0, 0, '0);

    // Clear while partly full: flags retained, buffer empties.
    applyStimulus("clr", 0, 0, 0, 1, '0);
    applyStimulus("post_clr", 0, 0, 0, 0, '0);

    // Concurrent write/read at constant occupancy across pointer wrap.
    resetDut();
    applyStimulus("wrap_prime", 1, 0, 0, 0, {$urandom()});
    for (int k = 0; k < 200; k++) applyStimulus("wrap", 1, 1, 0, 0, {$urandom()});
    for (int k = 0; k < 4; k++) applyStimulus("wrap_tail", 0, 1, 0, 0, '0);

    // Randomized traffic including mode changes and clears.
    begin
      logic m;
      m = 1'b0;
      for (int k = 0; k < 800; k++) begin
        if ($urandom_range(0, 19) == 0) m = ~m;
        applyStimulus("random", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 40),
                      m, ($urandom_range(0, 99) < 2), {$urandom()});
      end
    end

    // Asynchronous reset in the middle of a stagger.
    resetDut();
    for (int w = 0; w < 4; w++) applyStimulus("pre_async", 1, 0, 1, 0, patWord(w));
    applyStimulus("pre_async_mode", 0, 0, 1, 0, '0);
    for (int k = 0; k < 3; k++) applyStimulus("async_stag", 0, 1, 1, 0, '0);
    rd = 0;
    resetDut();
    applyStimulus("after_async", 0, 0, 0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
